// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI responder byte engine.
// Holds the frame width, the underrun fill byte and the framing FSM states.
package spi_pkg;

   localparam int SPI_BITS = 8;

   localparam logic [SPI_BITS-1:0] SPI_UNDERRUN_BYTE = 8'hFF;

   typedef logic [$clog2(SPI_BITS)-1:0] bit_cnt_t;

   localparam bit_cnt_t SPI_LAST_BIT = bit_cnt_t'(SPI_BITS - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } spi_state_e;

endpackage

// File: rtl/spi_responder_if.sv
// Core-side byte bus of the SPI responder: tx holding-register handshake
// plus rx byte strobe. slave = responder side, master = core logic side.
interface spi_responder_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_underrun;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  rx_data,
      input  rx_valid,
      input  tx_underrun
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output rx_data,
      output rx_valid,
      output tx_underrun
   );

endinterface

// File: rtl/spi_pin_sync.sv
// Pin synchroniser: SYNC_STAGES flops plus a history flop.
// Ports: clk, rst_n (sync, active-low), pin_i -> level_o, rise_o, fall_o.
module spi_pin_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         hist_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = level_o & ~hist_q;
   assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/spi_responder.sv
// SPI target byte engine: MISO driven on SCLK rise, MOSI sampled on fall.
// Ports: clk, rst_n (sync, active-low), spi_clk, spi_mosi, spi_cs_n (only
// with SPI_RESPONDER_CS_EN), spi_miso, core (spi_responder_if.slave:
// tx_data/tx_valid/tx_ready, rx_data/rx_valid, tx_underrun).
module spi_responder
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic spi_clk,
   input  logic spi_mosi,
`ifdef SPI_RESPONDER_CS_EN
   input  logic spi_cs_n,
`endif
   output logic spi_miso,
   spi_responder_if.slave core
);

   logic sclk_rise;
   logic sclk_fall;
   logic sclk_lvl_unused;
   logic mosi_lvl;
   logic mosi_rise_unused;
   logic mosi_fall_unused;
   logic cs_sel;

   spi_pin_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .RST_VAL    (1'b0)
   ) u_sclk (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_i  (spi_clk),
      .level_o(sclk_lvl_unused),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   spi_pin_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .RST_VAL    (1'b0)
   ) u_mosi (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_i  (spi_mosi),
      .level_o(mosi_lvl),
      .rise_o (mosi_rise_unused),
      .fall_o (mosi_fall_unused)
   );

`ifdef SPI_RESPONDER_CS_EN
   logic cs_lvl;
   logic cs_rise_unused;
   logic cs_fall_unused;

   // Reset to deselected so nothing shifts until CS_N is seen low.
   spi_pin_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .RST_VAL    (1'b1)
   ) u_cs (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_i  (spi_cs_n),
      .level_o(cs_lvl),
      .rise_o (cs_rise_unused),
      .fall_o (cs_fall_unused)
   );

   assign cs_sel = ~cs_lvl;
`else
   // No chip select: framing free-runs from reset release.
   assign cs_sel = 1'b1;
`endif

   spi_state_e          state_q;
   spi_state_e          state_d;
   bit_cnt_t            bit_cnt_q;
   bit_cnt_t            bit_cnt_d;
   logic [SPI_BITS-1:0] tx_shift_q;
   logic [SPI_BITS-1:0] tx_shift_d;
   logic [SPI_BITS-1:0] rx_shift_q;
   logic [SPI_BITS-1:0] rx_shift_d;
   logic [SPI_BITS-1:0] rx_data_q;
   logic [SPI_BITS-1:0] rx_data_d;
   logic [SPI_BITS-1:0] hold_q;
   logic [SPI_BITS-1:0] hold_d;
   logic                hold_full_q;
   logic                hold_full_d;
   logic                rx_valid_q;
   logic                rx_valid_d;
   logic                underrun_q;
   logic                underrun_d;
   logic                miso_q;
   logic                miso_d;
   logic [SPI_BITS-1:0] load_byte;
   logic [SPI_BITS-1:0] rx_next;
   logic                tx_accept;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (cs_sel) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (!cs_sel) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   assign tx_accept = core.tx_valid & ~hold_full_q;
   assign rx_next   = {rx_shift_q[SPI_BITS-2:0], mosi_lvl};

   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      tx_shift_d  = tx_shift_q;
      rx_shift_d  = rx_shift_q;
      rx_data_d   = rx_data_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rx_valid_d  = 1'b0;
      underrun_d  = 1'b0;
      miso_d      = miso_q;
      load_byte   = tx_shift_q;

      if (!cs_sel) begin
         bit_cnt_d  = '0;
         rx_shift_d = '0;
         miso_d     = 1'b0;
      end else if (state_q == SHIFT) begin
         if (sclk_rise) begin
            // First rise of a byte pulls the holding register.
            if (bit_cnt_q == '0) begin
               load_byte   = hold_full_q ? hold_q : SPI_UNDERRUN_BYTE;
               underrun_d  = ~hold_full_q;
               hold_full_d = 1'b0;
            end
            miso_d     = load_byte[SPI_BITS-1];
            tx_shift_d = {load_byte[SPI_BITS-2:0], 1'b0};
         end
         if (sclk_fall) begin
            rx_shift_d = rx_next;
            bit_cnt_d  = bit_cnt_q + bit_cnt_t'(1);
            if (bit_cnt_q == SPI_LAST_BIT) begin
               rx_data_d  = rx_next;
               rx_valid_d = 1'b1;
            end
         end
      end

      // A write only lands when the register was empty at the edge, so a
      // same-cycle load always takes the old byte.
      if (tx_accept) begin
         hold_d      = core.tx_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_cnt_q   <= '0;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         rx_data_q   <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         miso_q      <= 1'b0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         rx_data_q   <= rx_data_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
         miso_q      <= miso_d;
      end
   end

   assign spi_miso         = miso_q;
   assign core.tx_ready    = ~hold_full_q;
   assign core.rx_data     = rx_data_q;
   assign core.rx_valid    = rx_valid_q;
   assign core.tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_responder.sv
// Testbench for spi_responder: bench-side SPI master, rx scoreboard,
// vector table plus hand sequences for handshake, reset and CS cases.
module tb_spi_responder;

   localparam int HALF = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic spi_clk;
   logic spi_mosi;
   logic spi_miso;
`ifdef SPI_RESPONDER_CS_EN
   logic spi_cs_n;
`endif

   int checks = 0;
   int failures = 0;
   int rx_seen = 0;
   int pushes = 0;
   int under_cnt = 0;
   logic [7:0] exp_q[$];

   spi_responder_if bus();

   spi_responder #(.SYNC_STAGES(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .spi_clk (spi_clk),
      .spi_mosi(spi_mosi),
`ifdef SPI_RESPONDER_CS_EN
      .spi_cs_n(spi_cs_n),
`endif
      .spi_miso(spi_miso),
      .core    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.rx_valid) begin
         rx_seen++;
         if (exp_q.size() == 0) begin
            chk("rx_unexpected", 32'(bus.rx_data), 32'hFFFF_FFFF);
         end else begin
            chk("rx_byte", 32'(bus.rx_data), 32'(exp_q.pop_front()));
         end
      end
      if (rst_n && bus.tx_underrun) under_cnt++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_tx(input logic [7:0] b);
      int n = 0;
      while (!bus.tx_ready && n < 400) begin
         cyc(1);
         n++;
      end
      if (!bus.tx_ready) chk("tx_ready_wait", 32'(bus.tx_ready), 32'd1);
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
      cyc(1);
      bus.tx_valid = 1'b0;
   endtask

   task automatic xfer(input logic [7:0] mo, input int nbits,
                       output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_mosi = mo[i];
         spi_clk  = 1'b1;
         cyc(HALF);
         spi_clk  = 1'b0;
         mi[i]    = spi_miso;
         cyc(HALF);
      end
   endtask

   typedef struct {
      logic       pre_en;
      logic [7:0] pre_b;
      logic       mid_en;
      logic [7:0] mid_b;
      logic [7:0] mosi;
      logic [7:0] miso;
      int         under;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] mi;
      int u0;
      int seen0;

      vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 8'h3C, 8'hA5, 0};
      vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h01, 8'hFF, 1};
      vecs[2] = '{1'b1, 8'hE1, 1'b1, 8'hE2, 8'h11, 8'hE1, 0};
      vecs[3] = '{1'b0, 8'h00, 1'b1, 8'hE3, 8'h22, 8'hE2, 0};
      vecs[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h33, 8'hE3, 0};
      vecs[5] = '{1'b1, 8'h00, 1'b0, 8'h00, 8'hFF, 8'h00, 0};
      vecs[6] = '{1'b1, 8'h80, 1'b0, 8'h00, 8'h7E, 8'h80, 0};

      rst_n        = 1'b0;
      spi_clk      = 1'b0;
      spi_mosi     = 1'b0;
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
`ifdef SPI_RESPONDER_CS_EN
      spi_cs_n     = 1'b0;
`endif
      cyc(5);
      chk("rst_miso", 32'(spi_miso), 32'd0);
      chk("rst_rx_data", 32'(bus.rx_data), 32'h00);
      chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
      chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
      chk("rst_underrun", 32'(bus.tx_underrun), 32'd0);
      rst_n = 1'b1;
      cyc(4);

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].pre_en) send_tx(vecs[i].pre_b);
         if (vecs[i].pre_en && !vecs[i].mid_en)
            chk("ready_low_pre", 32'(bus.tx_ready), 32'd0);
         u0 = under_cnt;
         exp_q.push_back(vecs[i].mosi);
         pushes++;
         fork
            xfer(vecs[i].mosi, 8, mi);
            begin
               if (vecs[i].mid_en) send_tx(vecs[i].mid_b);
            end
         join
         chk($sformatf("miso_v%0d", i), 32'(mi), 32'(vecs[i].miso));
         chk($sformatf("under_v%0d", i), 32'(under_cnt - u0),
             32'(vecs[i].under));
         chk($sformatf("rx_data_v%0d", i), 32'(bus.rx_data),
             32'(vecs[i].mosi));
         if (vecs[i].pre_en && !vecs[i].mid_en)
            chk("ready_high_post", 32'(bus.tx_ready), 32'd1);
      end

      // tx_valid held while the holding register is full
      send_tx(8'h96);
      bus.tx_data  = 8'h69;
      bus.tx_valid = 1'b1;
      cyc(6);
      chk("hold_ready_low", 32'(bus.tx_ready), 32'd0);
      exp_q.push_back(8'h42);
      pushes++;
      xfer(8'h42, 8, mi);
      chk("hold_miso_old", 32'(mi), 32'h96);
      chk("hold_accepted", 32'(bus.tx_ready), 32'd0);
      bus.tx_valid = 1'b0;
      exp_q.push_back(8'h24);
      pushes++;
      u0 = under_cnt;
      xfer(8'h24, 8, mi);
      chk("hold_miso_new", 32'(mi), 32'h69);
      chk("hold_under", 32'(under_cnt - u0), 32'd0);

      // reset in the middle of a byte
      send_tx(8'h77);
      seen0 = rx_seen;
      xfer(8'hB0, 3, mi);
      send_tx(8'h78);
      spi_mosi = 1'b0;
      rst_n = 1'b0;
      cyc(2);
      chk("mid_rst_miso", 32'(spi_miso), 32'd0);
      chk("mid_rst_rx_data", 32'(bus.rx_data), 32'h00);
      chk("mid_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
      chk("mid_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
      chk("mid_rst_underrun", 32'(bus.tx_underrun), 32'd0);
      rst_n = 1'b1;
      cyc(4);
      chk("mid_rst_no_rx", 32'(rx_seen - seen0), 32'd0);
      send_tx(8'hC5);
      exp_q.push_back(8'h5A);
      pushes++;
      xfer(8'h5A, 8, mi);
      chk("post_rst_miso", 32'(mi), 32'hC5);
      chk("post_rst_rx", 32'(bus.rx_data), 32'h5A);

`ifdef SPI_RESPONDER_CS_EN
      // deselect after 5 bits: partial byte dropped
      seen0 = rx_seen;
      xfer(8'h99, 5, mi);
      spi_cs_n = 1'b1;
      cyc(8);
      chk("cs_miso_low", 32'(spi_miso), 32'd0);
      chk("cs_no_rx", 32'(rx_seen - seen0), 32'd0);
      spi_cs_n = 1'b0;
      cyc(6);
      send_tx(8'h3A);
      exp_q.push_back(8'hC3);
      pushes++;
      xfer(8'hC3, 8, mi);
      chk("cs_miso", 32'(mi), 32'h3A);
      chk("cs_rx", 32'(bus.rx_data), 32'hC3);
`endif

      cyc(4);
      chk("rx_count", 32'(rx_seen), 32'(pushes));
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_responder.md
# spi_responder

SPI target-side byte engine answering the team's SPI master: it receives bytes on `spi_mosi` and returns bytes on `spi_miso` using the same clocking convention as the master. The master changes MOSI on the rising SCLK edge and samples MISO on the falling edge. Asynchronous SPI pins are synchronised into `clk`. The block presents a byte-wide receive strobe and a ready/valid transmit holding register to the core logic.

## Interface
Parameters:
- SYNC_STAGES, 2, flops in each pin synchroniser before the edge-detect register (≥2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- spi_clk  in  1  SCLK from master, idle low, asynchronous.
- spi_mosi  in  1  data from master, asynchronous.
- spi_cs_n  in  1  chip select, active-low; present only with SPI_RESPONDER_CS_EN.
- spi_miso  out  1  data to master.
- tx_data  in  8  next byte to send.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  holding register empty; a transfer occurs when tx_valid && tx_ready.
- rx_data  out  8  last complete received byte, held until the next byte completes.
- rx_valid  out  1  one-cycle strobe when rx_data updates.
- tx_underrun  out  1  one-cycle strobe when a byte starts with the holding register empty.

## Operation
- The SCLK, MOSI and CS_N pins all pass through identical SYNC_STAGES chains plus one history register, so MOSI is aligned with the SCLK edge.
  - rise = sync & ~hist.
  - fall = ~sync & hist.
- States:
  - IDLE: waiting for a frame.
  - SHIFT: bit_cnt tracks position 0..7.
- IDLE→SHIFT:
  - With CS: on synchronised CS_N low.
  - Without CS: leave IDLE after reset deassertion.
- Rising edge, bit_cnt==0:
  - The shift register loads from the holding register.
  - If the holding register is empty, the shift register loads 8'hFF and tx_underrun pulses.
  - The holding register empties, so tx_ready rises the next cycle.
- Every rising edge: spi_miso <= tx_shift[7], then tx_shift shifts left. The data is MSB first.
- Falling edge: rx_shift <= {rx_shift[6:0], mosi_sync} and bit_cnt increments.
  - On the 8th fall (bit_cnt 7→0 wrap), rx_data <= the completed byte and rx_valid pulses.
  - The FSM stays in SHIFT for the next byte, which supports back-to-back bytes.
- tx handshake: when tx_valid && tx_ready, capture tx_data and tx_ready falls the next cycle.
  - Load-and-empty in the same cycle: the load of the shift register takes the old holding byte. The new write is accepted only when tx_ready was high that cycle.
- Rise and fall are never detected in the same cycle. No other simultaneous events need arbitration.
- Reset mid-byte: all state is cleared and the partial byte is discarded.

## Timing
- Reset values:
  - spi_miso 0, rx_data 8'h00, rx_valid 0, tx_ready 1, tx_underrun 0.
  - bit_cnt 0, FSM IDLE (without CS: SHIFT after reset).
- Edge detection latency: SYNC_STAGES+1 clk cycles from the pin edge.
- rx_valid: asserted on the cycle after the falling edge is detected, for exactly 1 cycle.
- spi_miso: updates the cycle after the rising edge is detected.
- Required SCLK half-period: ≥ SYNC_STAGES+2 clk cycles. With the master on the same clk and SYNC_STAGES=2, the master divider must be ≥3.
- tx_ready: drops 1 cycle after the handshake and rises 1 cycle after the shift-register load.

## Configuration
- SPI_RESPONDER_CS_EN defined:
  - `spi_cs_n` port exists.
  - CS_N high (synchronised) forces IDLE, clears bit_cnt and rx_shift, and holds spi_miso at 0.
  - A partial byte is dropped with no rx_valid.
  - The holding register is kept.
- SPI_RESPONDER_CS_EN undefined:
  - No CS port. Framing counts 8 falling edges continuously from reset.
  - The master and responder must come out of reset together.

## Structure
- Shared package `spi_pkg`:
  - SPI_UNDERRUN_BYTE = 8'hFF.
  - SPI_BITS = 8.
  - State enum {IDLE, SHIFT}.
- Sub-module `spi_pin_sync`: a SYNC_STAGES synchroniser plus history register, outputting level, rise and fall. It is instantiated per pin, and MOSI uses its level only.

## Test plan
- Preload tx 8'hA5, master sends 8'h3C with divider 3 → master reads 8'hA5; rx_data=8'h3C with one rx_valid pulse; tx_ready rises after the first SCLK rise.
- No tx preload, master sends 8'h01 → tx_underrun pulses once; master reads 8'hFF; rx_data=8'h01.
- Three back-to-back bytes 8'h11/22/33, with the holding register refilled on each tx_ready → three rx_valid pulses in order; master reads the matching tx bytes.
- CS_EN: raise CS_N after 5 bits, then run a full byte 8'hC3 → no rx_valid for the partial byte; rx_data=8'hC3; spi_miso=0 while deselected.
- Assert rst_n low mid-byte, then run 8'h5A → all outputs at reset values during reset; next byte received as 8'h5A.
- tx_valid held with tx_ready low → no overwrite; the byte is accepted only when tx_ready returns.
